// File: rtl/move_controller.sv
// Connect-four move controller: validates drop requests, tracks column heights and turns,
// and issues one board write per accepted move. Optional single-level undo under UNDO_EN.
module move_controller #(
    parameter int   ROWS         = 6,
    parameter int   COLS         = 7,
    parameter logic START_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] col_addr,
    input  logic       col_valid,
    input  logic       drop,
    input  logic       game_over,
`ifdef UNDO_EN
    input  logic       undo,
    output logic       wr_clear,
`endif
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic       wr_player,
    output logic       current_player,
    output logic [5:0] move_count,
    output logic       reject,
    output logic       board_full,
    output logic       busy
);

    localparam logic [2:0] ROWS_H = 3'(ROWS);
    localparam logic [3:0] COLS_W = 4'(COLS);
    localparam logic [5:0] CELLS  = 6'(ROWS * COLS);

`ifdef UNDO_EN
    typedef enum logic [1:0] {IDLE, CHECK, WRITE, UNDO} state_t;
`else
    typedef enum logic [1:0] {IDLE, CHECK, WRITE} state_t;
`endif

    state_t                state;
    logic [COLS-1:0][2:0]  height;
    logic                  drop_q;
    logic                  valid_r;
    logic [2:0]            col_r;
    logic [2:0]            h_sel;
    logic                  drop_edge;
    logic                  illegal;

    assign drop_edge = drop & ~drop_q;

    // Mux by comparison so an out-of-range col_r never indexes past the array.
    always_comb begin
        h_sel = '0;
        for (int i = 0; i < COLS; i++)
            if (col_r == 3'(i)) h_sel = height[i];
    end

    assign illegal = !valid_r || ({1'b0, col_r} >= COLS_W) || (h_sel >= ROWS_H)
                     || board_full || game_over;

`ifdef UNDO_EN
    logic       undo_q;
    logic       undo_edge;
    logic       last_v;
    logic [2:0] last_col;
    logic [2:0] h_last;

    assign undo_edge = undo & ~undo_q;

    always_comb begin
        h_last = '0;
        for (int i = 0; i < COLS; i++)
            if (last_col == 3'(i)) h_last = height[i];
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            height         <= '0;
            drop_q         <= 1'b0;
            valid_r        <= 1'b0;
            col_r          <= '0;
            move_count     <= '0;
            board_full     <= 1'b0;
            current_player <= START_PLAYER;
            wr_en          <= 1'b0;
            wr_row         <= '0;
            wr_col         <= '0;
            wr_player      <= 1'b0;
            reject         <= 1'b0;
            busy           <= 1'b0;
`ifdef UNDO_EN
            undo_q         <= 1'b0;
            wr_clear       <= 1'b0;
            last_v         <= 1'b0;
            last_col       <= '0;
`endif
        end else begin
            drop_q <= drop;
            wr_en  <= 1'b0;
            reject <= 1'b0;
`ifdef UNDO_EN
            undo_q   <= undo;
            wr_clear <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (drop_edge) begin
                        col_r   <= col_addr;
                        valid_r <= col_valid;
                        state   <= CHECK;
                        busy    <= 1'b1;
                    end
`ifdef UNDO_EN
                    else if (undo_edge) begin
                        if (last_v && !game_over) begin
                            state <= UNDO;
                            busy  <= 1'b1;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
`endif
                end
                CHECK: begin
                    if (illegal) begin
                        reject <= 1'b1;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        wr_row    <= ROWS_H - 3'd1 - h_sel;
                        wr_col    <= col_r;
                        wr_player <= current_player;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    wr_en <= 1'b1;
                    for (int i = 0; i < COLS; i++)
                        if (col_r == 3'(i) && height[i] != ROWS_H) height[i] <= height[i] + 3'd1;
                    if (move_count != CELLS) move_count <= move_count + 6'd1;
                    board_full     <= (move_count >= CELLS - 6'd1);
                    current_player <= ~current_player;
`ifdef UNDO_EN
                    last_col <= col_r;
                    last_v   <= 1'b1;
`endif
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef UNDO_EN
                UNDO: begin
                    // Top piece of a column holding h pieces sits at row ROWS-h.
                    wr_en     <= 1'b1;
                    wr_clear  <= 1'b1;
                    wr_row    <= ROWS_H - h_last;
                    wr_col    <= last_col;
                    wr_player <= ~current_player;
                    for (int i = 0; i < COLS; i++)
                        if (last_col == 3'(i) && height[i] != 3'd0) height[i] <= height[i] - 3'd1;
                    if (move_count != 6'd0) move_count <= move_count - 6'd1;
                    board_full     <= 1'b0;
                    current_player <= ~current_player;
                    last_v         <= 1'b0;
                    state          <= IDLE;
                    busy           <= 1'b0;
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: stimulus pushes expected write/reject events with
// their due cycle; a negedge monitor pops and compares whenever wr_en or reject is seen.
module tb_move_controller;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] col_addr = '0;
    logic       col_valid = 1'b0;
    logic       drop = 1'b0;
    logic       game_over = 1'b0;
    logic       wr_en, wr_player, current_player, reject, board_full, busy;
    logic [2:0] wr_row, wr_col;
    logic [5:0] move_count;
`ifdef UNDO_EN
    logic       undo = 1'b0;
    logic       wr_clear;
`endif

    move_controller dut (
        .clk(clk), .resetn(resetn), .col_addr(col_addr), .col_valid(col_valid),
        .drop(drop), .game_over(game_over),
`ifdef UNDO_EN
        .undo(undo), .wr_clear(wr_clear),
`endif
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_player(wr_player),
        .current_player(current_player), .move_count(move_count), .reject(reject),
        .board_full(board_full), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         rej;
        logic [2:0] row;
        logic [2:0] col;
        logic       player;
        logic       clr;
        int         due;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int   h[7];
    int   mc;
    logic pl;
    bit   lv;
    int   lc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    exp_t e;
    always @(negedge clk) begin
        if (wr_en || reject) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: wr_en=%0b reject=%0b with nothing expected (cycle %0d)",
                         wr_en, reject, cyc);
            end else begin
                e = q.pop_front();
                chk("event_is_reject", int'(reject), int'(e.rej));
                chk("event_cycle", cyc, e.due);
                if (!e.rej) begin
                    chk("wr_row", int'(wr_row), int'(e.row));
                    chk("wr_col", int'(wr_col), int'(e.col));
                    chk("wr_player", int'(wr_player), int'(e.player));
`ifdef UNDO_EN
                    chk("wr_clear", int'(wr_clear), int'(e.clr));
`endif
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 7; i++) h[i] = 0;
        mc = 0;
        pl = 1'b0;
        lv = 1'b0;
        lc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        drop = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic press(input logic [2:0] c, input logic v, input int hold);
        exp_t x;
        bit   legal;
        @(negedge clk);
        col_addr  = c;
        col_valid = v;
        legal = v && (int'(c) < 7) && !game_over && (mc < 42);
        if (legal) legal = (h[c] < 6);
        x.rej = !legal; x.row = '0; x.col = c; x.player = pl; x.clr = 1'b0;
        if (legal) begin
            x.row = 3'(5 - h[c]);
            x.due = cyc + 3;
            h[c]++; mc++; pl = ~pl; lv = 1'b1; lc = int'(c);
        end else begin
            x.due = cyc + 2;
        end
        q.push_back(x);
        drop = 1'b1;
        repeat (hold) @(negedge clk);
        drop = 1'b0;
        repeat (4) @(negedge clk);
    endtask

`ifdef UNDO_EN
    task automatic press_undo();
        exp_t x;
        @(negedge clk);
        x.rej = !(lv && !game_over); x.row = '0; x.col = 3'(lc); x.player = ~pl; x.clr = 1'b1;
        if (!x.rej) begin
            x.row = 3'(6 - h[lc]);
            x.due = cyc + 2;
            h[lc]--; mc--; pl = ~pl; lv = 1'b0;
        end else begin
            x.due = cyc + 1;
        end
        q.push_back(x);
        undo = 1'b1;
        @(negedge clk);
        undo = 1'b0;
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        model_reset();
        #1;
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_reject", int'(reject), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_move_count", int'(move_count), 0);
        chk("rst_player", int'(current_player), 0);
        chk("rst_board_full", int'(board_full), 0);
        chk("rst_wr_row", int'(wr_row), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Single move in column 3, busy while in flight
        @(negedge clk);
        col_addr = 3'd3; col_valid = 1'b1; drop = 1'b1;
        q.push_back('{1'b0, 3'd5, 3'd3, 1'b0, 1'b0, cyc + 3});
        h[3] = 1; mc = 1; pl = 1'b1; lv = 1'b1; lc = 3;
        @(negedge clk);
        chk("busy_in_check", int'(busy), 1);
        drop = 1'b0;
        repeat (4) @(negedge clk);
        chk("mc_after_first", int'(move_count), 1);
        chk("player_after_first", int'(current_player), 1);
        chk("busy_idle", int'(busy), 0);

        // Fill column 0, seventh drop rejected
        do_reset();
        for (int i = 0; i < 7; i++) press(3'd0, 1'b1, 1);
        chk("mc_col0_full", int'(move_count), 6);

        // Invalid address / flag
        press(3'd2, 1'b0, 1);
        press(3'd7, 1'b1, 1);
        chk("mc_after_invalid", int'(move_count), 6);
        press(3'd1, 1'b1, 1);
        press(3'd2, 1'b1, 1);

        // Held key: one write only
        press(3'd2, 1'b1, 20);
        chk("mc_after_hold", int'(move_count), 9);

        // Reset in CHECK cycle
        @(negedge clk);
        col_addr = 3'd4; col_valid = 1'b1; drop = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        drop = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_mc", int'(move_count), 0);
        chk("midrst_player", int'(current_player), 0);
        resetn = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        press(3'd0, 1'b1, 1);
        press(3'd4, 1'b1, 1);

        // Fill the whole board
        do_reset();
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) press(3'(c), 1'b1, 1);
        chk("full_mc", int'(move_count), 42);
        chk("full_flag", int'(board_full), 1);
        press(3'd3, 1'b1, 1);
        chk("full_mc_after_43", int'(move_count), 42);

        // game_over blocks drops on an empty column
        do_reset();
        game_over = 1'b1;
        press(3'd4, 1'b1, 1);
        chk("gameover_mc", int'(move_count), 0);
        game_over = 1'b0;
        press(3'd4, 1'b1, 1);
        chk("gameover_cleared_mc", int'(move_count), 1);

`ifdef UNDO_EN
        do_reset();
        press(3'd2, 1'b1, 1);
        press_undo();
        chk("undo_mc", int'(move_count), 0);
        chk("undo_player", int'(current_player), 0);
        press_undo();
        press(3'd2, 1'b1, 1);
`endif

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
